// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU sharing sequencer:
// widths, ALU opcode encodings, FSM states and the opcode legality check.
package alu_share_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for both ports of the ALU sharing sequencer.
// Index 0 is the main datapath, index 1 the auxiliary unit.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [1:0][DATA_W-1:0]      req_a;
  logic [1:0][DATA_W-1:0]      req_b;
  logic [1:0][OP_W-1:0]        req_op;
  logic [1:0]                  rsp_valid;
  logic [1:0]                  rsp_ready;
  logic [DATA_W-1:0]           rsp_result;
  logic                        rsp_zero;
  logic                        rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_share_arbiter_rr_picker.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// port named by ptr wins.
module alu_rr_picker (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = valid;
    if (&valid) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Sequencer sharing one external combinational ALU between two requesters:
// accept one op, present registered operands for a cycle, return the result.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_zero
);

  state_e            state_q, state_d;
  logic              owner_q;
  logic              rr_ptr_q;
  logic [1:0]        grant;
  logic              grant_port;
  logic              accept;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              err_q;

  alu_rr_picker u_picker (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign grant_port = grant[1];

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = grant;
        accept        = |grant;
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a   <= bus.req_a[grant_port];
        alu_b   <= bus.req_b[grant_port];
        alu_op  <= bus.req_op[grant_port];
        owner_q <= grant_port;
      end
      if (state_q == ST_EXEC) begin
        rr_ptr_q <= ~owner_q;
        // Illegal opcodes ignore whatever the ALU drives and report a flagged zero.
        if (op_legal(alu_op)) begin
          result_q <= alu_o;
          zero_q   <= alu_zero;
          err_q    <= 1'b0;
        end else begin
          result_q <= '0;
          zero_q   <= 1'b1;
          err_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural team ALU attached.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_o;
  logic [2:0]  alu_op;
  logic        alu_zero;
  int          n_vec;
  int          n_bad;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_o    (alu_o),
    .alu_zero (alu_zero)
  );

  // Team ALU: SLT yields 1 when A <= B signed; undefined opcodes drive junk.
  always_comb begin
    alu_o = 32'hDEAD_BEEF;
    case (alu_op)
      3'b000:  alu_o = alu_a & alu_b;
      3'b001:  alu_o = alu_a | alu_b;
      3'b010:  alu_o = alu_a + alu_b;
      3'b110:  alu_o = alu_a - alu_b;
      3'b111:  alu_o = ($signed(alu_a) <= $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_o = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_o == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.rsp_ready  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one request on port p, waits for the response and consumes it.
  // lat counts rising edges from the accepting edge to the first visible response.
  task automatic do_txn(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, output logic [1:0] vld,
                        output logic [31:0] res, output logic z, output logic e,
                        output int lat);
    int w;
    bus.req_valid[p] = 1'b1;
    bus.req_a[p]     = a;
    bus.req_b[p]     = b;
    bus.req_op[p]    = op;
    #1;
    w = 0;
    while (bus.req_ready[p] !== 1'b1 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[p] = 1'b0;
    lat = 1;
    while (bus.rsp_valid === 2'b00 && lat < 20) begin
      @(negedge clk); lat++;
    end
    vld = bus.rsp_valid;
    res = bus.rsp_result;
    z   = bus.rsp_zero;
    e   = bus.rsp_err;
    bus.rsp_ready[p] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_vec++; if (bus.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b exp 00", bus.rsp_valid); end
    n_vec++; if (bus.rsp_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h exp 0", bus.rsp_result); end
    n_vec++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) begin n_bad++; $display("FAIL reset_zero_err: got %b exp 00", {bus.rsp_zero, bus.rsp_err}); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_bad++; $display("FAIL reset_alu_regs: got %h %h %b exp 0", alu_a, alu_b, alu_op); end
    n_vec++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready_idle: got %b exp 00", bus.req_ready); end
    bus.req_valid = 2'b10; #1;
    n_vec++; if (bus.req_ready !== 2'b10) begin n_bad++; $display("FAIL reset_ready_p1: got %b exp 10", bus.req_ready); end
    bus.req_valid = 2'b11; #1;
    n_vec++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL reset_ready_tie: got %b exp 01", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [1:0] v; logic [31:0] r; logic z, e; int lat;
    do_txn(0, 32'd3, 32'd4, OP_ADD, v, r, z, e, lat);
    n_vec++; if (v !== 2'b01) begin n_bad++; $display("FAIL add_vld: got %b exp 01", v); end
    n_vec++; if (r !== 32'd7) begin n_bad++; $display("FAIL add_result: got %h exp 7", r); end
    n_vec++; if ({z, e} !== 2'b00) begin n_bad++; $display("FAIL add_zero_err: got %b exp 00", {z, e}); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d exp 2", lat); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== {32'd3, 32'd4, 3'b010}) begin n_bad++; $display("FAIL add_alu_held: got %h %h %b exp 3 4 010", alu_a, alu_b, alu_op); end
  endtask

  task automatic test_round_robin();
    logic [1:0] v; logic [31:0] r; logic z, e; int lat;
    reset_dut();
    bus.req_valid = 2'b11;
    bus.req_a[0] = 32'd9;     bus.req_b[0] = 32'd9;     bus.req_op[0] = OP_SUB;
    bus.req_a[1] = 32'h0000_00F0; bus.req_b[1] = 32'h0000_000F; bus.req_op[1] = OP_OR;
    #1;
    n_vec++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL rr1_ready: got %b exp 01", bus.req_ready); end
    do_txn(0, 32'd9, 32'd9, OP_SUB, v, r, z, e, lat);
    n_vec++; if (v !== 2'b01) begin n_bad++; $display("FAIL rr_sub_vld: got %b exp 01", v); end
    n_vec++; if ({r, z} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL rr_sub_result: got %h z=%b exp 0 z=1", r, z); end
    #1;
    n_vec++; if (bus.req_ready !== 2'b10) begin n_bad++; $display("FAIL rr_loser_ready: got %b exp 10", bus.req_ready); end
    do_txn(1, 32'h0000_00F0, 32'h0000_000F, OP_OR, v, r, z, e, lat);
    n_vec++; if (v !== 2'b10) begin n_bad++; $display("FAIL rr_or_vld: got %b exp 10", v); end
    n_vec++; if ({r, z} !== {32'h0000_00FF, 1'b0}) begin n_bad++; $display("FAIL rr_or_result: got %h z=%b exp ff z=0", r, z); end
    bus.req_valid = 2'b11;
    bus.req_a[0] = 32'd1;  bus.req_b[0] = 32'd1;  bus.req_op[0] = OP_ADD;
    bus.req_a[1] = 32'hFF; bus.req_b[1] = 32'h0F; bus.req_op[1] = OP_AND;
    #1;
    n_vec++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL rr3_ready: got %b exp 01", bus.req_ready); end
    do_txn(0, 32'd1, 32'd1, OP_ADD, v, r, z, e, lat);
    n_vec++; if ({v, r} !== {2'b01, 32'd2}) begin n_bad++; $display("FAIL rr3_p0: got %b %h exp 01 2", v, r); end
    #1;
    n_vec++; if (bus.req_ready !== 2'b10) begin n_bad++; $display("FAIL rr3_loser_ready: got %b exp 10", bus.req_ready); end
    do_txn(1, 32'hFF, 32'h0F, OP_AND, v, r, z, e, lat);
    n_vec++; if ({v, r} !== {2'b10, 32'h0F}) begin n_bad++; $display("FAIL rr3_p1: got %b %h exp 10 f", v, r); end
  endtask

  task automatic test_slt();
    logic [1:0] v; logic [31:0] r; logic z, e; int lat;
    do_txn(0, 32'hFFFF_FFFF, 32'd1, OP_SLT, v, r, z, e, lat);
    n_vec++; if ({r, z} !== {32'd1, 1'b0}) begin n_bad++; $display("FAIL slt_neg: got %h z=%b exp 1 z=0", r, z); end
    do_txn(0, 32'd5, 32'd5, OP_SLT, v, r, z, e, lat);
    n_vec++; if (r !== 32'd1) begin n_bad++; $display("FAIL slt_equal: got %h exp 1", r); end
    do_txn(0, 32'd1, 32'h8000_0000, OP_SLT, v, r, z, e, lat);
    n_vec++; if ({r, z} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL slt_min: got %h z=%b exp 0 z=1", r, z); end
  endtask

  task automatic test_bad_op();
    logic [1:0] v; logic [31:0] r; logic z, e; int lat;
    do_txn(1, 32'h1234_5678, 32'h1234_5678, 3'b100, v, r, z, e, lat);
    n_vec++; if (v !== 2'b10) begin n_bad++; $display("FAIL bad100_vld: got %b exp 10", v); end
    n_vec++; if ({r, z, e} !== {32'd0, 2'b11}) begin n_bad++; $display("FAIL bad100_result: got %h z=%b e=%b exp 0 1 1", r, z, e); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL bad100_latency: got %0d exp 2", lat); end
    do_txn(0, 32'd0, 32'd0, 3'b011, v, r, z, e, lat);
    n_vec++; if ({v, r, z, e} !== {2'b01, 32'd0, 2'b11}) begin n_bad++; $display("FAIL bad011: got %b %h z=%b e=%b exp 01 0 1 1", v, r, z, e); end
  endtask

  task automatic test_back_to_back_hold();
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_a[0] = 32'h10; bus.req_b[0] = 32'h20; bus.req_op[0] = OP_ADD;
    #1;
    n_vec++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL hold_accept_ready: got %b exp 01", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_a[1] = 32'h20; bus.req_b[1] = 32'h10; bus.req_op[1] = OP_SUB;
    #1;
    n_vec++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL hold_exec_ready: got %b exp 00", bus.req_ready); end
    @(negedge clk);
    n_vec++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_err} !== {2'b01, 32'h30, 1'b0}) begin n_bad++; $display("FAIL hold_first_rsp: got %b %h e=%b exp 01 30 0", bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
    bus.rsp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if ({bus.rsp_valid, bus.rsp_result, bus.req_ready} !== {2'b01, 32'h30, 2'b00}) begin n_bad++; $display("FAIL hold_cycle%0d: got %b %h rdy=%b exp 01 30 00", i, bus.rsp_valid, bus.rsp_result, bus.req_ready); end
    end
    bus.rsp_ready[1] = 1'b0;
    bus.rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready[0] = 1'b0;
    #1;
    n_vec++; if ({bus.rsp_valid, bus.req_ready} !== {2'b00, 2'b10}) begin n_bad++; $display("FAIL hold_after_consume: got %b rdy=%b exp 00 10", bus.rsp_valid, bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b10, 32'h10}) begin n_bad++; $display("FAIL hold_second_rsp: got %b %h exp 10 10", bus.rsp_valid, bus.rsp_result); end
    bus.rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] v; logic [31:0] r; logic z, e; int lat;
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_a[0] = 32'd1; bus.req_b[0] = 32'd2; bus.req_op[0] = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b00, 32'd0}) begin n_bad++; $display("FAIL midrst_rsp: got %b %h exp 00 0", bus.rsp_valid, bus.rsp_result); end
    n_vec++; if ({alu_a, alu_op} !== {32'd0, 3'b000}) begin n_bad++; $display("FAIL midrst_alu: got %h %b exp 0 000", alu_a, alu_op); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_stale%0d: got %b exp 00", i, bus.rsp_valid); end
    end
    do_txn(1, 32'd5, 32'd6, OP_ADD, v, r, z, e, lat);
    n_vec++; if ({v, r, z, e} !== {2'b10, 32'd11, 2'b00}) begin n_bad++; $display("FAIL midrst_next: got %b %h z=%b e=%b exp 10 b 0 0", v, r, z, e); end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL midrst_latency: got %0d exp 2", lat); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_add();
    test_round_robin();
    test_slt();
    test_bad_op();
    test_back_to_back_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
